// File: rtl/fast_sampler_n_if.sv
// Signal bundle between the acquisition controller and the fast-domain sampler.
// The controller side uses the master modport and the sampler uses the slave modport.
interface fast_sampler_n_if #(
    parameter int CHANNELS   = 16,
    parameter int WORD_WIDTH = 16,
    parameter int DIV_WIDTH  = 8,
    parameter int CNT_WIDTH  = 32
);
    logic [CHANNELS-1:0]   probe;
    logic                  acq_enable;
    logic [DIV_WIDTH-1:0]  clock_divisor;
    logic [CHANNELS-1:0]   channel_enable;
    logic [CNT_WIDTH-1:0]  sample_limit;
    logic                  overflow;
    logic [WORD_WIDTH-1:0] sample_data;
    logic                  sample_data_avail;
    logic                  stalled;
    logic                  done;
    logic [CNT_WIDTH-1:0]  sample_count;

    modport master (
        output probe, acq_enable, clock_divisor, channel_enable, sample_limit, overflow,
        input  sample_data, sample_data_avail, stalled, done, sample_count
    );

    modport slave (
        input  probe, acq_enable, clock_divisor, channel_enable, sample_limit, overflow,
        output sample_data, sample_data_avail, stalled, done, sample_count
    );
endinterface

// File: rtl/fast_sampler_n.sv
// Fast-domain acquisition front end: synchronises probes, samples them on a divided tick,
// packs per-channel words (LSB oldest) and emits enabled channels as a gap-free burst.
module fast_sampler_n #(
    parameter int CHANNELS   = 16,
    parameter int WORD_WIDTH = 16,
    parameter int DIV_WIDTH  = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic            clk,
    input  logic            rst,
    fast_sampler_n_if.slave bus
);
    localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int IDX_W = $clog2(CHANNELS + 1);
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(WORD_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [CHANNELS-1:0]   sync_meta;
    logic [CHANNELS-1:0]   sync_q;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  done_q;
    logic                  stalled_q;
    logic [WORD_WIDTH-1:0] shift_q [CHANNELS];
    logic [WORD_WIDTH-1:0] latch_q [CHANNELS];
    logic [CHANNELS-1:0]   valid_q;

    logic                  clear;
    logic                  tick;
    logic                  word_ready;
    logic [CNT_WIDTH-1:0]  count_next;
    logic [WORD_WIDTH-1:0] word      [CHANNELS];
    logic [IDX_W-1:0]      prefix    [CHANNELS];
    logic [IDX_W-1:0]      n_enabled;
    logic [WORD_WIDTH-1:0] load_data [CHANNELS];
    logic [CHANNELS-1:0]   load_valid;

    assign clear      = rst | ~bus.acq_enable;
    assign tick       = bus.acq_enable & ~done_q & (div_cnt == bus.clock_divisor);
    assign word_ready = tick & (bit_cnt == LAST_BIT);
    assign count_next = (count_q == CNT_MAX) ? count_q : count_q + CNT_WIDTH'(1);

    // Two-flop synchroniser; runs independently of acq_enable so it is settled at start.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= bus.probe;
            sync_q    <= sync_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            stalled_q <= stalled_q | bus.overflow;
            if (done_q || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
            end
            if (tick) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
                count_q <= count_next;
                if ((bus.sample_limit != '0) && (count_next == bus.sample_limit)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Word as it would look after this tick: new sample enters at the MSB.
    // NOTE: every variable written here is assigned on every path, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            word[i] = (shift_q[i] >> 1) | (WORD_WIDTH'(sync_q[i]) << (WORD_WIDTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (clear) begin
                shift_q[i] <= '0;
            end else if (tick && bus.channel_enable[i]) begin
                shift_q[i] <= word[i];
            end
        end
    end

    // prefix[i] is the number of enabled channels below i, i.e. the slot channel i lands in.
    always_comb begin
        n_enabled = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            prefix[i] = n_enabled;
            n_enabled = n_enabled + IDX_W'(bus.channel_enable[i]);
        end
    end

    always_comb begin
        load_valid = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            load_data[k]  = '0;
            load_valid[k] = (IDX_W'(k) < n_enabled);
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.channel_enable[i] && (prefix[i] == IDX_W'(k))) begin
                    load_data[k] = word[i];
                end
            end
        end
    end

    // Output chain: parallel load of the compacted words, then one slot per cycle toward slot 0.
    // NOTE: the slot array is reset explicitly because latch_q[0] drives sample_data directly.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int k = 0; k < CHANNELS; k++) begin
                latch_q[k] <= '0;
            end
            valid_q <= '0;
        end else if (word_ready) begin
            for (int k = 0; k < CHANNELS; k++) begin
                latch_q[k] <= load_data[k];
            end
            valid_q <= load_valid;
        end else begin
            for (int k = 0; k < CHANNELS - 1; k++) begin
                latch_q[k] <= latch_q[k+1];
            end
            latch_q[CHANNELS-1] <= '0;
            valid_q             <= valid_q >> 1;
        end
    end

    assign bus.sample_data       = latch_q[0];
    assign bus.sample_data_avail = valid_q[0] & ~stalled_q & ~bus.overflow;
    assign bus.stalled           = stalled_q;
    assign bus.done              = done_q;
    assign bus.sample_count      = count_q;
endmodule

// File: doc/fast_sampler_n.md
Name: fast_sampler_n

Overview:
- Parametrised fast-clock-domain acquisition front end.
- Synchronises CHANNELS probe inputs and samples them at clk/(clock_divisor+1).
- Packs each enabled channel's samples into WORD_WIDTH-bit words, LSB = oldest sample.
- Emits the words as a compacted burst: enabled channels only, ascending channel order, consecutive cycles. Adds a programmable sample limit with a done flag, and a stall that re-arms per acquisition. Sits between the probe pins and the cross-clock FIFO writer.

Parameters:
- CHANNELS, 16, number of probe channels; legal range 1..WORD_WIDTH.
- WORD_WIDTH, 16, samples per output word.
- DIV_WIDTH, 8, width of clock_divisor.
- CNT_WIDTH, 32, width of sample_limit and sample_count.

Ports:
- clk, in, 1: sampling clock.
- rst, in, 1: reset.
- probe, in, CHANNELS: asynchronous probe inputs.
- acq_enable, in, 1: acquisition running; low clears the datapath.
- clock_divisor, in, DIV_WIDTH: tick period minus 1; held static while acq_enable=1.
- channel_enable, in, CHANNELS: per-channel enable; held static while acq_enable=1.
- sample_limit, in, CNT_WIDTH: ticks to acquire; 0 = unlimited.
- overflow, in, 1: downstream FIFO full.
- sample_data, out, WORD_WIDTH: output word.
- sample_data_avail, out, 1: sample_data valid this cycle.
- stalled, out, 1: sticky overflow indication.
- done, out, 1: sample limit reached.
- sample_count, out, CNT_WIDTH: ticks taken this acquisition.

Behaviour:
- Reset and clocking: reset rst, synchronous, active-high; clock clk. rst clears all registers. Every output is 0 while in reset.
- Probe synchroniser: 2-flop chain per channel, reset to 0. The synchronised bit reaches the sampler 2 cycles after the probe edge.
- Divider: counter div_cnt is forced to 0 when acq_enable=0, done=1, or rst.
  - Otherwise tick=(div_cnt==clock_divisor). On tick, div_cnt<=0; else div_cnt<=div_cnt+1.
  - With divisor D, the first tick is on the (D+1)th enabled cycle; tick period is D+1 cycles. D=0 gives a tick every cycle.
- Bit counter: bit_cnt counts 0..WORD_WIDTH-1, shared by all channels. It advances on tick and wraps to 0. It is cleared when acq_enable=0.
- Shifting: on tick, each enabled channel does shift[i] <= {sync[i], shift[i][WORD_WIDTH-1:1]}.
- Word completion: word_ready = tick & (bit_cnt==WORD_WIDTH-1). The completed word is {sync[i], shift[i][WORD_WIDTH-1:1]}.
- Output chain: CHANNELS slots, each holding latch[k] and valid[k].
  - acq_enable=0: all slots are cleared.
  - On word_ready: slot k loads the word of the k-th enabled channel (ascending index, computed by prefix count) with valid=1. Slots k >= popcount(channel_enable) load 0 with valid=0.
  - Otherwise slot k <= slot k+1, and the top slot <= 0/invalid.
- Output timing: the data of the k-th enabled channel appears on sample_data at word_ready cycle + 1 + k. Words arrive on consecutive cycles with no gaps.
- Drain guarantee: (D+1)*WORD_WIDTH >= CHANNELS, so the chain always drains before the next load. Load overrides shift if both fall in the same cycle.
- Outputs: sample_data = latch[0]; sample_data_avail = valid[0] & !stalled & !overflow.
- Stall: stalled_q <= (stalled_q | overflow) & acq_enable. It is sticky within an acquisition and cleared when acq_enable drops.
  - Overflow suppresses sample_data_avail in the same cycle it is asserted. Words suppressed this way are lost; the chain keeps shifting.
- Counting: sample_count is cleared when acq_enable=0 and increments on each tick, saturating at all-ones.
  - done is set in the cycle after the tick that makes sample_count==sample_limit, with sample_limit≠0.
  - done is sticky until acq_enable=0 or rst. While done=1, no further ticks occur.
  - Words already completed still drain through the chain. A partial word at done is discarded.
- acq_enable dropping mid-burst: all slots, bit_cnt, div_cnt, sample_count, done and stalled clear on the next edge. sample_data_avail is 0 from the following cycle.
- channel_enable=0 with acq_enable=1: ticks and sample_count still run, but sample_data_avail never asserts.

Test Plan:
1. Reset with defaults: hold rst 3 cycles while acq_enable=1 -> all outputs 0 during and 1 cycle after reset.
2. Divisor 0, all 16 channels enabled, probe[i]=i odd?1:0 static -> first word_ready 18 cycles after sync settles.
   - 16 consecutive avail cycles carry 0x0000/0xFFFF alternating, starting with ch0=0x0000.
   - Burst repeats every 16 cycles.
3. channel_enable=16'h8021, D=3, probe[5] toggling each tick -> 3 consecutive avail cycles per word (ch0, ch5=0xAAAA or 0x5555, ch15), then none until the next word, 64 cycles later.
4. sample_limit=32, D=0, all channels enabled -> exactly 2 bursts of 16 words; done rises 1 cycle after the 32nd tick; sample_count holds at 32.
   - Repeat with sample_limit=40 -> still 2 bursts, sample_count=40.
5. Overflow pulse 1 cycle mid-burst -> avail drops for the remainder; stalled=1 and stays 1. acq_enable low 1 cycle then high -> stalled=0 and a new acquisition produces bursts.
6. acq_enable deasserted at burst word 4 -> avail 0 from the next cycle. Re-enable -> first burst after a full WORD_WIDTH*(D+1) tick period, sample_count restarts at 0.
